// File: rtl/quadrature_encoder_gen_pkg.sv
// Shared types and constants for the quadrature encoder generator:
// FSM states, the phase-to-(A,B) Gray table and direction codes.
package quadrature_encoder_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Phase index 0..3 maps to (A,B) = 00, 10, 11, 01; bits [2p+1:2p] hold phase p.
  localparam logic [7:0] AB_GRAY = {2'b01, 2'b11, 2'b10, 2'b00};

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  function automatic logic [1:0] ab_of(input logic [1:0] phase);
    return AB_GRAY[{phase, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quadrature_encoder_gen_if.sv
// Command channel of the encoder generator. Handshake: a command transfers on
// a rising clk edge where cmd_valid and cmd_ready are both high; payload is
// only sampled on that edge.
interface quadrature_encoder_gen_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 16
) ();
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [DATA_WIDTH-1:0]   cmd_steps;
  logic [PERIOD_WIDTH-1:0] cmd_period;

  modport master (output cmd_valid, output cmd_steps, output cmd_period, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_steps, input cmd_period, output cmd_ready);
endinterface

// File: rtl/quadrature_encoder_gen_step_timer.sv
// Edge-period counter: restarts at 1 on start, counts while run, and raises
// tick in the cycle where the count reaches period (then reloads to 1).
module quadrature_encoder_gen_step_timer #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    run,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    tick
);

  logic [PERIOD_WIDTH-1:0] count;

  assign tick = run && (count == period);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      count <= PERIOD_WIDTH'(1);
    end else if (run) begin
      if (count == period) count <= PERIOD_WIDTH'(1);
      else                 count <= count + PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/quadrature_encoder_gen.sv
// Emits a commanded burst of quadrature A/B transitions at a fixed edge
// period and tracks the signed position in decoder count convention.
module quadrature_encoder_gen
  import quadrature_encoder_gen_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter int MIN_PERIOD   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  quadrature_encoder_gen_if.slave cmd,
  input  logic                  abort,
  output logic                  enc_a,
  output logic                  enc_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] position,
  output state_t                fsm_state
);

  state_t                  state_q, state_d;
  logic [1:0]              phase_q, phase_next;
  logic                    dir_q;
  logic [DATA_WIDTH-1:0]   remaining_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [DATA_WIDTH-1:0]   steps_mag;
  logic [PERIOD_WIDTH-1:0] period_clamped;
  logic                    accept;
  logic                    tick;
  logic                    step_edge;

  assign cmd.cmd_ready = (state_q == IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state_q == WAIT);
  assign done          = (state_q == DONE);
  assign fsm_state     = state_q;

  // Unsigned magnitude: the most negative count maps to 2^(W-1), which still fits.
  assign steps_mag      = cmd.cmd_steps[DATA_WIDTH-1] ? (~cmd.cmd_steps + DATA_WIDTH'(1))
                                                      : cmd.cmd_steps;
  assign period_clamped = (cmd.cmd_period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD)
                                                                       : cmd.cmd_period;

  // abort outranks a coincident edge.
  assign step_edge  = (state_q == WAIT) && !abort && tick;
  assign phase_next = (dir_q == DIR_FWD) ? (phase_q + 2'd1) : (phase_q - 2'd1);

  quadrature_encoder_gen_step_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .run    ((state_q == WAIT) && !abort),
    .period (period_q),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (cmd.cmd_steps == '0) ? DONE : WAIT;
      end
      WAIT: begin
        if (abort) state_d = IDLE;
        else if (step_edge && (remaining_q == DATA_WIDTH'(1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 2'd0;
      enc_a       <= 1'b0;
      enc_b       <= 1'b0;
      position    <= '0;
      dir_q       <= DIR_FWD;
      remaining_q <= '0;
      period_q    <= PERIOD_WIDTH'(MIN_PERIOD);
    end else begin
      state_q <= state_d;
      if (accept) begin
        dir_q       <= cmd.cmd_steps[DATA_WIDTH-1] ? DIR_REV : DIR_FWD;
        remaining_q <= steps_mag;
        period_q    <= period_clamped;
      end
      if (step_edge) begin
        phase_q        <= phase_next;
        {enc_a, enc_b} <= ab_of(phase_next);
        position       <= (dir_q == DIR_FWD) ? (position + DATA_WIDTH'(1))
                                             : (position - DATA_WIDTH'(1));
        remaining_q    <= remaining_q - DATA_WIDTH'(1);
      end
    end
  end

endmodule
